// File: rtl/verificador_prbs11.sv
// verificador_prbs11: self-synchronising PRBS-11 (x^11+x^9+1) serial checker with lock, error pulse and count.
// Error counter built only when VERIFICADOR_PRBS11_CONTADOR_EN is defined; otherwise contador_erros is 0.
module verificador_prbs11 #(
  parameter int N_TRAVA = 16,
  parameter int N_PERDA = 4,
  parameter int W_CONT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valido,
  input  logic              entrada,
  output logic              travado,
  output logic              erro,
  output logic [W_CONT-1:0] contador_erros
);
  localparam int WT = $clog2(N_TRAVA + 1);
  localparam int WP = $clog2(N_PERDA + 1);
  typedef enum logic {BUSCA, TRAVADO} estado_t;
  estado_t estado_q, estado_d;
  logic [10:0] h_q, h_d;
  logic [3:0] fill_q, fill_d;
  logic [WT-1:0] ct_q, ct_d;
  logic [WP-1:0] cp_q, cp_d;
  logic erro_q, erro_d;
  logic p, dif;
  assign p   = h_q[8] ^ h_q[10];
  assign dif = p ^ entrada;
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= BUSCA;
      h_q      <= '0;
      fill_q   <= '0;
      ct_q     <= '0;
      cp_q     <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      h_q      <= h_d;
      fill_q   <= fill_d;
      ct_q     <= ct_d;
      cp_q     <= cp_d;
      erro_q   <= erro_d;
    end
  end
  // Locked: shift in the prediction so one line error gives exactly one pulse
  always_comb begin
    estado_d = estado_q;
    h_d      = h_q;
    fill_d   = fill_q;
    ct_d     = ct_q;
    cp_d     = cp_q;
    if (valido && estado_q == BUSCA) begin
      h_d    = {h_q[9:0], entrada};
      fill_d = (fill_q == 4'd11) ? fill_q : fill_q + 4'd1;
      if (fill_q == 4'd11)
        ct_d = (dif || h_d == '0) ? '0 : ct_q + 1'b1;
      if (ct_d == WT'(N_TRAVA) && h_d != '0) begin
        estado_d = TRAVADO;
        ct_d     = '0;
      end
    end else if (valido) begin
      h_d  = {h_q[9:0], p};
      cp_d = dif ? cp_q + 1'b1 : '0;
      if (cp_d == WP'(N_PERDA)) begin
        estado_d = BUSCA;
        fill_d   = '0;
        ct_d     = '0;
        cp_d     = '0;
      end
    end
  end
  always_comb begin
    erro_d = valido && estado_q == TRAVADO && dif;
  end
  assign travado = estado_q == TRAVADO;
  assign erro    = erro_q;
`ifdef VERIFICADOR_PRBS11_CONTADOR_EN
  logic [W_CONT-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (erro_d && ~&cnt_q) cnt_q <= cnt_q + 1'b1;
  end
  assign contador_erros = cnt_q;
`else
  assign contador_erros = '0;
`endif
endmodule

// File: tb/tb_verificador_prbs11.sv
// tb_verificador_prbs11: directed checks of lock, single error, loss/relock, dead line, gapped valid and reset.
module tb_verificador_prbs11;
`ifdef VERIFICADOR_PRBS11_CONTADOR_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, valido = 1'b0, entrada = 1'b0;
  logic travado, erro;
  logic [15:0] contador_erros;
  logic [10:0] g;
  int checks = 0, errors = 0;
  int acc, erro_cnt, lock_at;
  verificador_prbs11 dut (
    .clk(clk), .rst(rst), .valido(valido), .entrada(entrada),
    .travado(travado), .erro(erro), .contador_erros(contador_erros)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  function automatic logic gen_bit();
    logic fb;
    fb = g[8] ^ g[10];
    g = {g[9:0], fb};
    return fb;
  endfunction
  task automatic send(input logic b, input logic v);
    entrada = b;
    valido  = v;
    @(posedge clk);
    #1;
    if (v) acc++;
    if (erro) erro_cnt++;
    if (travado && lock_at == 0) lock_at = acc;
  endtask
  task automatic clr_trk();
    acc = 0;
    erro_cnt = 0;
    lock_at = 0;
  endtask
  task automatic clean(input int n);
    for (int i = 0; i < n; i++) send(gen_bit(), 1'b1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    valido = 1'b1;
    entrada = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    valido = 1'b0;
    g = 11'h7FF;
    clr_trk();
  endtask
  initial begin
    do_reset();
    chk("reset_travado", {31'd0, travado}, 32'd0);
    chk("reset_erro", {31'd0, erro}, 32'd0);
    chk("reset_cont", {16'd0, contador_erros}, 32'd0);
    // clean lock
    clean(26);
    chk("lock_not_before_27", {31'd0, travado}, 32'd0);
    clean(2000 - 26);
    chk("clean_lock_at", lock_at, 27);
    chk("clean_erro_pulses", erro_cnt, 0);
    chk("clean_cont", {16'd0, contador_erros}, 32'd0);
    chk("clean_travado", {31'd0, travado}, 32'd1);
    // single flip
    clr_trk();
    send(~gen_bit(), 1'b1);
    chk("flip_erro_pulse", {31'd0, erro}, 32'd1);
    clean(30);
    chk("flip_erro_count", erro_cnt, 1);
    chk("flip_cont", {16'd0, contador_erros}, CE ? 32'd1 : 32'd0);
    chk("flip_travado", {31'd0, travado}, 32'd1);
    // loss and relock
    do_reset();
    clean(40);
    clr_trk();
    for (int i = 0; i < 3; i++) send(~gen_bit(), 1'b1);
    chk("loss_still_locked_3", {31'd0, travado}, 32'd1);
    send(~gen_bit(), 1'b1);
    chk("loss_4th_erro", {31'd0, erro}, 32'd1);
    chk("loss_travado_falls", {31'd0, travado}, 32'd0);
    chk("loss_erro_count", erro_cnt, 4);
    clr_trk();
    clean(60);
    chk("relock_at", lock_at, 27);
    chk("relock_erro", erro_cnt, 0);
    chk("loss_cont", {16'd0, contador_erros}, CE ? 32'd4 : 32'd0);
    // dead line
    do_reset();
    for (int i = 0; i < 500; i++) send(1'b0, 1'b1);
    chk("dead_never_lock", lock_at, 0);
    chk("dead_erro", erro_cnt, 0);
    // gapped valid
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(1, 0) == 1) send(gen_bit(), 1'b1);
      else send(1'($urandom_range(1, 0)), 1'b0);
    end
    chk("gap_lock_at", lock_at, 27);
    chk("gap_erro", erro_cnt, 0);
    chk("gap_travado", {31'd0, travado}, 32'd1);
    // reset mid-lock
    do_reset();
    clean(40);
    for (int i = 0; i < 3; i++) begin
      send(~gen_bit(), 1'b1);
      clean(3);
    end
    chk("mid_travado", {31'd0, travado}, 32'd1);
    chk("mid_cont", {16'd0, contador_erros}, CE ? 32'd3 : 32'd0);
    rst = 1'b1;
    entrada = gen_bit();
    valido = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_travado", {31'd0, travado}, 32'd0);
    chk("rst_cont", {16'd0, contador_erros}, 32'd0);
    chk("rst_erro", {31'd0, erro}, 32'd0);
    clr_trk();
    clean(40);
    chk("rst_relock_at", lock_at, 27);
    chk("rst_relock_erro", erro_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
